elbeth_trap_ctrl: RTL

Trap and return sequencer for the ELBETH core. It sits beside the decoder in the ID stage and watches the exception, environment-call and eret indications for the instruction in ID, plus the external interrupt line. When one fires it stalls and flushes the pipeline, writes `mepc` and `mcause` through the CSR file's write port, and redirects the fetch PC to `mtvec` (trap) or `mepc` (eret).

---
 rtl/elbeth_trap_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/elbeth_trap_ctrl.sv
// elbeth_trap_ctrl: trap/eret sequencer writing mepc/mcause and redirecting fetch
module elbeth_trap_ctrl #(
  parameter logic [11:0] CSR_MEPC_ADDR   = 12'h341,
  parameter logic [11:0] CSR_MCAUSE_ADDR = 12'h342,
  parameter logic [31:0] IRQ_CAUSE       = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_illegal_instruction,
  input  logic [3:0]  id_except_src,
  input  logic        id_ecall,
  input  logic        id_ebreak,
  input  logic        id_eret,
  input  logic        ext_irq,
  input  logic        csr_mie,
  input  logic [1:0]  csr_prv,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        trap_stall,
  output logic        trap_flush,
  output logic        trap_csr_we,
  output logic [11:0] trap_csr_addr,
  output logic [31:0] trap_csr_wdata,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);
  typedef enum logic [2:0] {IDLE, SAVE_EPC, SAVE_CAUSE, REDIRECT, ERET} state_t;
  state_t state, state_d;
  logic [31:0] epc_q, cause_q, cause_d;
  logic irq, trap_ev, eret_ev, idle;
  assign idle    = state == IDLE;
  assign irq     = ext_irq & csr_mie;
  assign trap_ev = id_valid & (irq | id_illegal_instruction | id_ebreak | id_ecall);
  assign eret_ev = id_valid & id_eret & ~trap_ev;
  // Fixed priority: interrupt, illegal, ebreak, ecall
  assign cause_d = irq ? IRQ_CAUSE :
                   id_illegal_instruction ? {28'b0, id_except_src} :
                   id_ebreak ? 32'd3 : 32'd8 + {30'b0, csr_prv};
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state <= state_d;
      if (idle && trap_ev) begin
        epc_q   <= id_pc;
        cause_q <= cause_d;
      end
    end
  end
  always_comb begin
    state_d        = IDLE;
    trap_stall     = 1'b0;
    trap_csr_we    = 1'b0;
    trap_csr_addr  = '0;
    trap_csr_wdata = '0;
    pc_redirect    = 1'b0;
    pc_target      = '0;
    trap_flush     = ~idle;
    case (state)
      IDLE: begin
        state_d    = trap_ev ? SAVE_EPC : eret_ev ? ERET : IDLE;
        trap_stall = trap_ev | eret_ev;
      end
      SAVE_EPC: begin
        state_d        = SAVE_CAUSE;
        trap_stall     = 1'b1;
        trap_csr_we    = 1'b1;
        trap_csr_addr  = CSR_MEPC_ADDR;
        trap_csr_wdata = epc_q;
      end
      SAVE_CAUSE: begin
        state_d        = REDIRECT;
        trap_stall     = 1'b1;
        trap_csr_we    = 1'b1;
        trap_csr_addr  = CSR_MCAUSE_ADDR;
        trap_csr_wdata = cause_q;
      end
      REDIRECT: begin
        pc_redirect = 1'b1;
        pc_target   = csr_mtvec & 32'hFFFF_FFFC;
      end
      ERET: begin
        pc_redirect = 1'b1;
        pc_target   = csr_mepc & 32'hFFFF_FFFC;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
